// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// waits on memory with a timeout, tracks privilege and raises traps.
module multicycle_controller #(
  parameter int          MEM_TIMEOUT = 16,
  parameter bit          HAS_USER    = 1'b1,
  parameter logic [1:0]  RESET_PRIV  = 2'b11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        ALUZero,
  input  logic        memReady,
  input  logic        interrupt,
  output logic        memRd,
  output logic        memWr,
  output logic        irWr,
  output logic        pcWr,
  output logic [1:0]  pcSel,
  output logic        regWr,
  output logic [2:0]  regDataSel,
  output logic [3:0]  ALUCtrl,
  output logic [1:0]  ALUSrc2,
  output logic        csrWr,
  output logic        mret,
  output logic        exception,
  output logic        intTaken,
  output logic [30:0] excCode,
  output logic [1:0]  privLevel
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [1:0] PRIV_U    = 2'b00;
  localparam logic [1:0] PRIV_M    = 2'b11;
  localparam logic [3:0] ALU_ADD   = 4'b0000;

  state_t      state, nextState;
  logic [7:0]  waitCnt;
  logic [4:0]  trapCode, nextTrapCode;
  logic        trapInt, nextTrapInt;
  logic [1:0]  nextPriv;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic        isEcall, isEbreak, isMret, isCsr, legal, branchTaken, timeoutHit;

  assign opcode     = instruction[6:0];
  assign funct3     = instruction[14:12];
  assign rs1        = instruction[19:15];
  assign isEcall    = (instruction == 32'h0000_0073);
  assign isEbreak   = (instruction == 32'h0010_0073);
  assign isMret     = (instruction == 32'h3020_0073);
  assign isCsr      = (opcode == OP_SYSTEM) && (funct3 != 3'b000);
  assign timeoutHit = (waitCnt == 8'(MEM_TIMEOUT - 1));

  // Only the exact ECALL/EBREAK/MRET encodings are legal with funct3=0 under SYSTEM
  always_comb begin
    legal = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_IMM, OP_REG: legal = 1'b1;
      OP_JALR:   legal = (funct3 == 3'b000);
      OP_BRANCH: legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      OP_LOAD:   legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OP_STORE:  legal = (funct3 <= 3'b010);
      OP_FENCE:  legal = (funct3 <= 3'b001);
      OP_SYSTEM: legal = (funct3 == 3'b000) ? (isEcall || isEbreak || isMret) : (funct3 != 3'b100);
      default:   legal = 1'b0;
    endcase
  end

  // BEQ/BGE/BGEU take the branch when the SUB/SLT/SLTU result is zero
  assign branchTaken = (funct3 == 3'b000 || funct3 == 3'b101 || funct3 == 3'b111) ? ALUZero : !ALUZero;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      waitCnt   <= 8'd0;
      privLevel <= RESET_PRIV;
      trapCode  <= 5'd0;
      trapInt   <= 1'b0;
    end else begin
      state     <= nextState;
      waitCnt   <= (nextState != state) ? 8'd0 : waitCnt + 8'd1;
      privLevel <= nextPriv;
      trapCode  <= nextTrapCode;
      trapInt   <= nextTrapInt;
    end
  end

  always_comb begin
    nextState    = state;
    nextPriv     = privLevel;
    nextTrapCode = trapCode;
    nextTrapInt  = trapInt;
    memRd        = 1'b0;
    memWr        = 1'b0;
    irWr         = 1'b0;
    pcWr         = 1'b0;
    pcSel        = 2'd0;
    regWr        = 1'b0;
    regDataSel   = 3'd0;
    ALUCtrl      = ALU_ADD;
    ALUSrc2      = 2'd0;
    csrWr        = 1'b0;
    mret         = 1'b0;
    exception    = 1'b0;
    intTaken     = 1'b0;
    excCode      = 31'd0;

    case (state)
      FETCH: begin
        memRd = 1'b1;
        if (memReady) begin
          irWr      = 1'b1;
          nextState = DECODE;
        end else if (timeoutHit) begin
          nextState    = TRAP;
          nextTrapCode = 5'd1;
          nextTrapInt  = 1'b0;
        end
      end

      DECODE: begin
        nextState   = TRAP;
        nextTrapInt = 1'b0;
        if (interrupt) begin
          nextTrapCode = 5'd11;
          nextTrapInt  = 1'b1;
        end else if (!legal || (isMret && privLevel == PRIV_U)) begin
          nextTrapCode = 5'd2;
        end else if (isEbreak) begin
          nextTrapCode = 5'd3;
        end else if (isEcall) begin
          nextTrapCode = 5'd8 + {3'b000, privLevel};
        end else begin
          nextState = EXEC;
        end
      end

      EXEC, WB: begin
        case (opcode)
          OP_REG: ALUCtrl = {instruction[30], funct3};
          OP_IMM: ALUCtrl = {instruction[30] && (funct3 == 3'b101), funct3};
          OP_BRANCH: ALUCtrl = funct3[2] ? (funct3[1] ? 4'b0011 : 4'b0010) : 4'b1000;
          default: ALUCtrl = ALU_ADD;
        endcase
        ALUSrc2 = isCsr ? 2'd2 : (opcode == OP_REG || opcode == OP_BRANCH) ? 2'd0 : 2'd1;
        if (state == EXEC) begin
          nextState = FETCH;
          case (opcode)
            OP_REG, OP_IMM, OP_LUI, OP_AUIPC: nextState = WB;
            OP_LOAD, OP_STORE: nextState = MEM;
            OP_BRANCH: begin
              pcWr  = 1'b1;
              pcSel = branchTaken ? 2'd1 : 2'd0;
            end
            OP_JAL, OP_JALR: begin
              regWr      = 1'b1;
              regDataSel = 3'd3;
              pcWr       = 1'b1;
              pcSel      = 2'd1;
            end
            OP_FENCE: pcWr = 1'b1;
            OP_SYSTEM: begin
              if (isMret) begin
                pcWr     = 1'b1;
                pcSel    = 2'd3;
                mret     = 1'b1;
                nextPriv = HAS_USER ? PRIV_U : PRIV_M;
              end else begin
                nextState = WB;
              end
            end
            default: nextState = FETCH;
          endcase
        end else begin
          regWr     = 1'b1;
          pcWr      = 1'b1;
          nextState = FETCH;
          case (opcode)
            OP_LUI:    regDataSel = 3'd1;
            OP_AUIPC:  regDataSel = 3'd2;
            OP_SYSTEM: regDataSel = 3'd4;
            OP_LOAD:   regDataSel = 3'd5;
            default:   regDataSel = 3'd0;
          endcase
          // Set/clear forms with a zero source are pure reads and must not touch the CSR
          csrWr = isCsr && !(funct3[1] && rs1 == 5'd0);
        end
      end

      MEM: begin
        ALUSrc2 = 2'd1;
        memRd   = (opcode == OP_LOAD);
        memWr   = (opcode != OP_LOAD);
        if (memReady) begin
          if (opcode == OP_LOAD) begin
            nextState = WB;
          end else begin
            pcWr      = 1'b1;
            nextState = FETCH;
          end
        end else if (timeoutHit) begin
          nextState    = TRAP;
          nextTrapCode = (opcode == OP_LOAD) ? 5'd5 : 5'd7;
          nextTrapInt  = 1'b0;
        end
      end

      TRAP: begin
        exception = 1'b1;
        intTaken  = trapInt;
        excCode   = {26'd0, trapCode};
        pcWr      = 1'b1;
        pcSel     = 2'd2;
        nextPriv  = PRIV_M;
        nextState = FETCH;
      end

      default: nextState = FETCH;
    endcase

    if (reset) begin
      memRd     = 1'b0;
      memWr     = 1'b0;
      irWr      = 1'b0;
      pcWr      = 1'b0;
      regWr     = 1'b0;
      csrWr     = 1'b0;
      mret      = 1'b0;
      exception = 1'b0;
      intTaken  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: per-instruction transaction model builds expected
// per-cycle outputs from the instruction semantics, compared every cycle against the DUT.
module tb_multicycle_controller;

  localparam int MEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0000_0013;
  logic        ALUZero = 1'b0;
  logic        memReady = 1'b0;
  logic        interrupt = 1'b0;
  logic        memRd, memWr, irWr, pcWr, regWr, csrWr, mret, exception, intTaken;
  logic [1:0]  pcSel, privLevel, unusedAluSrc2;
  logic [2:0]  regDataSel;
  logic [3:0]  unusedAluCtrl;
  logic [30:0] excCode;

  multicycle_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .HAS_USER(1'b1), .RESET_PRIV(2'b11)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .ALUZero(ALUZero),
    .memReady(memReady), .interrupt(interrupt), .memRd(memRd), .memWr(memWr),
    .irWr(irWr), .pcWr(pcWr), .pcSel(pcSel), .regWr(regWr), .regDataSel(regDataSel),
    .ALUCtrl(unusedAluCtrl), .ALUSrc2(unusedAluSrc2), .csrWr(csrWr), .mret(mret),
    .exception(exception), .intTaken(intTaken), .excCode(excCode), .privLevel(privLevel)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ALU, K_LUI, K_AUIPC, K_LOAD, K_STORE, K_BRANCH, K_JUMP, K_FENCE,
                    K_CSR, K_MRET, K_ECALL, K_EBREAK, K_ILL} kind_t;

  typedef struct {
    bit       rdy, irq, zero;
    bit       memRd, memWr, irWr, pcWr, regWr, csrWr, mret, exc, intT;
    bit [1:0] pcSel, priv;
    bit [2:0] rds;
    int       code;
  } cyc_t;

  cyc_t        seq[$];
  logic [31:0] curInstr;
  bit   [1:0]  priv = 2'b11;
  int          checks = 0, errors = 0;
  int          obsCycles, obsPcWr, obsMemRd, obsMret, obsExcAt, obsCode, obsInt, obsPcSelExc;

  logic [2:0] loadF3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0] brF3   [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [2:0] csrF3  [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};
  logic [6:0] badOp  [6] = '{7'h00, 7'h7F, 7'h0B, 7'h2B, 7'h5B, 7'h57};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic kind_t kindOf(input logic [31:0] i);
    logic [2:0] f3 = i[14:12];
    case (i[6:0])
      7'h37: return K_LUI;
      7'h17: return K_AUIPC;
      7'h6F: return K_JUMP;
      7'h67: return (f3 == 3'd0) ? K_JUMP : K_ILL;
      7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BRANCH;
      7'h03: return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? K_LOAD : K_ILL;
      7'h23: return (f3 < 3'd3) ? K_STORE : K_ILL;
      7'h13, 7'h33: return K_ALU;
      7'h0F: return (f3 < 3'd2) ? K_FENCE : K_ILL;
      7'h73: begin
        if (i == 32'h0000_0073) return K_ECALL;
        if (i == 32'h0010_0073) return K_EBREAK;
        if (i == 32'h3020_0073) return K_MRET;
        return (f3 == 3'd0 || f3 == 3'd4) ? K_ILL : K_CSR;
      end
      default: return K_ILL;
    endcase
  endfunction

  function automatic cyc_t mk();
    cyc_t c = '{default: 0};
    c.rdy  = 1'($urandom);
    c.irq  = ($urandom_range(0, 3) == 0);
    c.zero = 1'($urandom);
    c.priv = priv;
    return c;
  endfunction

  task automatic pushTrap(input int code, input bit intr);
    cyc_t c = mk();
    c.exc = 1; c.intT = intr; c.code = code; c.pcWr = 1; c.pcSel = 2;
    seq.push_back(c);
    priv = 2'b11;
  endtask

  task automatic pushWb(input kind_t k, input logic [31:0] ins);
    cyc_t c = mk();
    c.regWr = 1; c.pcWr = 1; c.pcSel = 0;
    c.rds = (k == K_LUI) ? 3'd1 : (k == K_AUIPC) ? 3'd2 : (k == K_CSR) ? 3'd4 :
            (k == K_LOAD) ? 3'd5 : 3'd0;
    // CSRRS/CSRRC(I) with a zero source only read the CSR
    c.csrWr = (k == K_CSR) && !(ins[13] && ins[19:15] == 5'd0);
    seq.push_back(c);
  endtask

  task automatic buildInstr(input logic [31:0] ins, input int fw, input int mw, input bit irq, input bit zero);
    cyc_t  c;
    kind_t k = kindOf(ins);
    bit    ld = (k == K_LOAD);
    curInstr = ins;
    if (fw >= MEM_TIMEOUT) begin
      repeat (MEM_TIMEOUT) begin c = mk(); c.rdy = 0; c.memRd = 1; seq.push_back(c); end
      pushTrap(1, 0);
      return;
    end
    repeat (fw) begin c = mk(); c.rdy = 0; c.memRd = 1; seq.push_back(c); end
    c = mk(); c.rdy = 1; c.memRd = 1; c.irWr = 1; seq.push_back(c);
    c = mk(); c.irq = irq; seq.push_back(c);
    if (irq) begin pushTrap(11, 1); return; end
    if (k == K_ILL || (k == K_MRET && priv == 2'b00)) begin pushTrap(2, 0); return; end
    if (k == K_EBREAK) begin pushTrap(3, 0); return; end
    if (k == K_ECALL) begin pushTrap(8 + int'(priv), 0); return; end
    c = mk();
    case (k)
      K_BRANCH: begin
        c.zero = zero; c.pcWr = 1;
        c.pcSel = ((ins[14:12] inside {3'd0, 3'd5, 3'd7}) ? zero : !zero) ? 2'd1 : 2'd0;
      end
      K_JUMP:  begin c.regWr = 1; c.rds = 3; c.pcWr = 1; c.pcSel = 1; end
      K_FENCE: begin c.pcWr = 1; c.pcSel = 0; end
      K_MRET:  begin c.pcWr = 1; c.pcSel = 3; c.mret = 1; end
      default: ;
    endcase
    seq.push_back(c);
    if (k == K_MRET) priv = 2'b00;
    if (k inside {K_ALU, K_LUI, K_AUIPC, K_CSR}) pushWb(k, ins);
    if (k == K_LOAD || k == K_STORE) begin
      if (mw >= MEM_TIMEOUT) begin
        repeat (MEM_TIMEOUT) begin c = mk(); c.rdy = 0; c.memRd = ld; c.memWr = !ld; seq.push_back(c); end
        pushTrap(ld ? 5 : 7, 0);
        return;
      end
      repeat (mw) begin c = mk(); c.rdy = 0; c.memRd = ld; c.memWr = !ld; seq.push_back(c); end
      c = mk(); c.rdy = 1; c.memRd = ld; c.memWr = !ld; c.pcWr = !ld; c.pcSel = 0;
      seq.push_back(c);
      if (ld) pushWb(k, ins);
    end
  endtask

  task automatic applyStimulus(input cyc_t c);
    instruction = curInstr;
    memReady    = c.rdy;
    interrupt   = c.irq;
    ALUZero     = c.zero;
  endtask

  task automatic checkOutput(input cyc_t c, input int idx);
    chk("memRd", memRd, c.memRd);
    chk("memWr", memWr, c.memWr);
    chk("irWr", irWr, c.irWr);
    chk("pcWr", pcWr, c.pcWr);
    chk("regWr", regWr, c.regWr);
    chk("csrWr", csrWr, c.csrWr);
    chk("mret", mret, c.mret);
    chk("exception", exception, c.exc);
    chk("privLevel", privLevel, c.priv);
    if (c.pcWr) chk("pcSel", pcSel, c.pcSel);
    if (c.regWr) chk("regDataSel", regDataSel, c.rds);
    if (c.exc) begin
      chk("excCode", int'(excCode), c.code);
      chk("intTaken", intTaken, c.intT);
    end
    obsCycles++;
    obsPcWr  += int'(pcWr);
    obsMemRd += int'(memRd);
    obsMret  += int'(mret);
    if (exception) begin
      obsExcAt = idx + 1; obsCode = int'(excCode); obsInt = int'(intTaken); obsPcSelExc = int'(pcSel);
    end
  endtask

  // Entered and left at 1ns after a rising edge
  task automatic runSeq(input int limit);
    obsCycles = 0; obsPcWr = 0; obsMemRd = 0; obsMret = 0;
    obsExcAt = -1; obsCode = -1; obsInt = -1; obsPcSelExc = -1;
    for (int i = 0; i < seq.size() && (limit < 0 || i < limit); i++) begin
      applyStimulus(seq[i]);
      #4;
      checkOutput(seq[i], i);
      @(posedge clk); #1;
    end
    seq.delete();
  endtask

  task automatic doReset();
    reset = 1'b1; memReady = 1'b1; interrupt = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #4;
    chk("rst_memRd", memRd, 0);
    chk("rst_irWr", irWr, 0);
    chk("rst_pcWr", pcWr, 0);
    chk("rst_exception", exception, 0);
    chk("rst_priv", privLevel, 3);
    @(posedge clk); #1;
    reset = 1'b0;
    priv  = 2'b11;
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r = $urandom;
    logic [31:0] ins;
    case ($urandom_range(0, 17))
      0:  ins = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, r[24:7], 7'h33};
      1:  ins = {r[31:7], 7'h13};
      2:  ins = {r[31:7], 7'h37};
      3:  ins = {r[31:7], 7'h17};
      4:  ins = {r[31:15], loadF3[$urandom_range(0, 4)], r[11:7], 7'h03};
      5:  ins = {r[31:15], 3'($urandom_range(0, 2)), r[11:7], 7'h23};
      6:  ins = {r[31:15], brF3[$urandom_range(0, 5)], r[11:7], 7'h63};
      7:  ins = {r[31:7], 7'h6F};
      8:  ins = {r[31:15], 3'b000, r[11:7], 7'h67};
      9:  ins = 32'h0FF0_000F;
      10: ins = {r[31:20], ($urandom_range(0, 1) == 1) ? 5'd0 : r[19:15], csrF3[$urandom_range(0, 5)], r[11:7], 7'h73};
      11: ins = 32'h0000_0073;
      12: ins = 32'h0010_0073;
      14: ins = 32'h1020_0073;
      15: ins = {r[31:7], badOp[$urandom_range(0, 5)]};
      16: case (r[1:0])
            2'd0: ins = {r[31:15], 3'b011, r[11:7], 7'h03};
            2'd1: ins = {r[31:15], 3'b010, r[11:7], 7'h63};
            2'd2: ins = {r[31:15], 3'b101, r[11:7], 7'h23};
            default: ins = {r[31:15], 3'b100, r[11:7], 7'h73};
          endcase
      default: ins = 32'h3020_0073;
    endcase
    return ins;
  endfunction

  function automatic int randWait();
    int p = $urandom_range(0, 99);
    if (p < 65) return 0;
    if (p < 95) return $urandom_range(1, 5);
    return MEM_TIMEOUT;
  endfunction

  initial begin
    $display("[TB] multicycle_controller bench start");
    doReset();

    buildInstr(32'h0050_0093, 0, 0, 0, 0); runSeq(-1);
    chk("addi_cycles", obsCycles, 4);
    chk("addi_pcwr_count", obsPcWr, 1);

    buildInstr(32'h0000_A103, 0, 2, 0, 0); runSeq(-1);
    chk("lw_cycles", obsCycles, 7);
    chk("lw_memrd_cycles", obsMemRd, 4);
    chk("lw_pcwr_count", obsPcWr, 1);

    buildInstr(32'h0050_0093, MEM_TIMEOUT, 0, 0, 0); runSeq(-1);
    chk("fetch_timeout_cycle", obsExcAt, 17);
    chk("fetch_timeout_code", obsCode, 1);
    chk("fetch_timeout_pcsel", obsPcSelExc, 2);

    buildInstr(32'h3020_0073, 0, 0, 0, 0); runSeq(-1);
    chk("mret_m_pulse", obsMret, 1);
    chk("mret_m_priv", privLevel, 0);
    buildInstr(32'h0000_0073, 0, 0, 0, 0); runSeq(-1);
    chk("ecall_u_code", obsCode, 8);
    chk("ecall_u_priv", privLevel, 3);
    buildInstr(32'h0000_0073, 0, 0, 0, 0); runSeq(-1);
    chk("ecall_m_code", obsCode, 11);
    chk("ecall_m_priv", privLevel, 3);
    buildInstr(32'h3020_0073, 0, 0, 0, 0); runSeq(-1);
    buildInstr(32'h3020_0073, 0, 0, 0, 0); runSeq(-1);
    chk("mret_u_code", obsCode, 2);
    chk("mret_u_nopulse", obsMret, 0);

    buildInstr(32'hFFFF_FFFF, 0, 0, 1, 0); runSeq(-1);
    chk("irq_over_illegal_int", obsInt, 1);
    chk("irq_over_illegal_code", obsCode, 11);

    buildInstr(32'h0020_A023, 0, 20, 0, 0); runSeq(5);
    reset = 1'b1; memReady = 1'b0;
    #4;
    chk("rst_mem_memWr", memWr, 0);
    chk("rst_mem_pcWr", pcWr, 0);
    @(posedge clk); #1;
    reset = 1'b0; priv = 2'b11;
    #4;
    chk("rst_mem_fetch_memRd", memRd, 1);
    chk("rst_mem_fetch_memWr", memWr, 0);
    @(posedge clk); #1;

    for (int n = 0; n < 400; n++) begin
      buildInstr(randInstr(), randWait(), randWait(), ($urandom_range(0, 9) == 0), 1'($urandom));
      runSeq(-1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
